// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared widths, load/store aluop codes, LSU state encoding and op classifiers
package mem_lsu_pkg;

    localparam int ALUOP_W   = 8;
    localparam int REG_W     = 32;
    localparam int REGADDR_W = 5;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUSY = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return lo[0];
            EXE_LW_OP, EXE_SW_OP:             return lo != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - req/ack data bus between the LSU (master) and data memory (slave)
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic             req;
    logic             we;
    logic [REG_W-1:0] addr;
    logic [3:0]       sel;
    logic [REG_W-1:0] wdata;
    logic [REG_W-1:0] rdata;
    logic             ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);

endinterface

// File: rtl/mem_lsu_fmt.sv
// rtl/mem_lsu_fmt.sv - byte-lane enables, store data replication and load extension (combinational)
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [REG_W-1:0]   reg2,
    input  logic [REG_W-1:0]   rdata,
    output logic [3:0]         sel,
    output logic [REG_W-1:0]   wdata,
    output logic [REG_W-1:0]   load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        byte_v   = rdata[31:24];
        byte_sel = 4'b1000;
        case (addr_lo)
            2'b01:   begin byte_v = rdata[23:16]; byte_sel = 4'b0100; end
            2'b10:   begin byte_v = rdata[15:8];  byte_sel = 4'b0010; end
            2'b11:   begin byte_v = rdata[7:0];   byte_sel = 4'b0001; end
            default: begin end
        endcase
        half_v   = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        half_sel = addr_lo[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel       = 4'b0000;
        wdata     = reg2;
        load_data = '0;
        case (aluop)
            EXE_LB_OP:  begin sel = byte_sel; load_data = {{24{byte_v[7]}}, byte_v}; end
            EXE_LBU_OP: begin sel = byte_sel; load_data = {24'd0, byte_v}; end
            EXE_LH_OP:  begin sel = half_sel; load_data = {{16{half_v[15]}}, half_v}; end
            EXE_LHU_OP: begin sel = half_sel; load_data = {16'd0, half_v}; end
            EXE_LW_OP:  begin sel = 4'b1111;  load_data = rdata; end
            EXE_SB_OP:  begin sel = byte_sel; wdata = {4{reg2[7:0]}}; end
            EXE_SH_OP:  begin sel = half_sel; wdata = {2{reg2[15:0]}}; end
            EXE_SW_OP:  begin sel = 4'b1111;  wdata = reg2; end
            default:    begin end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit; defining LSU_ALIGN_CHECK_EN adds the misalign output
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALUOP_W-1:0]   mem_aluop,
    input  logic [REG_W-1:0]     mem_mem_addr,
    input  logic [REG_W-1:0]     mem_reg2,
    input  logic [REGADDR_W-1:0] mem_wd,
    input  logic                 mem_wreg,
    input  logic [REG_W-1:0]     mem_wdata,
    input  logic                 pipe_hold,
    output logic [REGADDR_W-1:0] wb_wd,
    output logic                 wb_wreg,
    output logic [REG_W-1:0]     wb_wdata,
    output logic                 stallreq,
    mem_lsu_if.master            dbus,
`ifdef LSU_ALIGN_CHECK_EN
    output logic                 misalign,
`endif
    output logic                 bus_err
);

    lsu_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [REG_W-1:0] addr_q, addr_d;
    logic [3:0]       sel_q, sel_d;
    logic [REG_W-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0] rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic             misalign_q, misalign_d;

    logic [3:0]       fmt_sel;
    logic [REG_W-1:0] fmt_wdata;
    logic [REG_W-1:0] fmt_load;
    logic             mem_op;
    logic             misal;
    logic             timeout;

    assign mem_op = is_mem_op(mem_aluop);

`ifdef LSU_ALIGN_CHECK_EN
    assign misal    = is_misaligned(mem_aluop, mem_mem_addr[1:0]);
    assign misalign = misalign_q;
`else
    assign misal    = 1'b0;
`endif

    // EX/MEM is frozen by stallreq, so mem_* still describe the op at ack time.
    mem_lsu_fmt u_fmt (
        .aluop     (mem_aluop),
        .addr_lo   (mem_mem_addr[1:0]),
        .reg2      (mem_reg2),
        .rdata     (dbus.rdata),
        .sel       (fmt_sel),
        .wdata     (fmt_wdata),
        .load_data (fmt_load)
    );

    generate
        if (ACK_TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)                     cnt_q <= '0;
                else if (state_q != LSU_BUSY) cnt_q <= '0;
                else                          cnt_q <= cnt_q + CNT_W'(1);
            end
            assign timeout = (state_q == LSU_BUSY) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        misalign_d = misalign_q;
        case (state_q)
            LSU_IDLE: begin
                if (mem_op) begin
                    if (misal) begin
                        misalign_d = 1'b1;
                        state_d    = LSU_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store(mem_aluop);
                        addr_d  = {mem_mem_addr[REG_W-1:2], 2'b00};
                        sel_d   = fmt_sel;
                        wdata_d = fmt_wdata;
                        state_d = LSU_BUSY;
                    end
                end
            end
            LSU_BUSY: begin
                // Ack is checked first so it beats a simultaneous timeout.
                if (dbus.ack) begin
                    rdata_d = fmt_load;
                    req_d   = 1'b0;
                    state_d = LSU_DONE;
                end else if (timeout) begin
                    rdata_d   = '0;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (!pipe_hold) begin
                    misalign_d = 1'b0;
                    state_d    = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LSU_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
        end
    end

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.sel   = sel_q;
    assign dbus.wdata = wdata_q;
    assign bus_err    = bus_err_q;

    always_comb begin
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        stallreq = (state_q == LSU_BUSY) || ((state_q == LSU_IDLE) && mem_op);
        if (mem_op) begin
            wb_wreg = 1'b0;
            if ((state_q == LSU_DONE) && is_load(mem_aluop) && !misalign_q) begin
                wb_wreg  = mem_wreg;
                wb_wdata = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu: vector table, corner sequences, randomized reference model
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int T = 4;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg, pipe_hold;
    logic [4:0]  wb_wd;
    logic        wb_wreg, stallreq, bus_err;
    logic [31:0] wb_wdata;
`ifdef LSU_ALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_lsu_if dbus();

    mem_lsu #(.ACK_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .pipe_hold    (pipe_hold),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .stallreq     (stallreq),
        .dbus         (dbus),
`ifdef LSU_ALIGN_CHECK_EN
        .misalign     (misalign),
`endif
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        logic [31:0] alu;
        int          ack_at;   // BUSY cycle carrying ack; 0 or > T means never
        int          hold;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] result;
        logic        wreg;
        logic        err;
    } vec_t;

    vec_t  tbl [11];
    int    n_checks = 0;
    int    n_fail   = 0;
    string cur      = "init";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: access size, lane offset and extension from plain arithmetic.
    function automatic int m_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            EXE_LW_OP, EXE_SW_OP:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [1:0] lo);
        int sz;
        int off;
        logic [7:0] ones;
        sz   = m_size(op);
        off  = (int'(lo) / sz) * sz;
        ones = 8'((1 << sz) - 1);
        return 4'(ones << (4 - sz - off));
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] lo, input logic [31:0] rd);
        int sz;
        int off;
        logic [63:0] mask;
        logic [63:0] v;
        sz   = m_size(op);
        off  = (int'(lo) / sz) * sz;
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = ({32'd0, rd} >> (8 * (4 - sz - off))) & mask;
        if (((op == EXE_LB_OP) || (op == EXE_LH_OP)) && v[8 * sz - 1])
            v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r2);
        case (m_size(op))
            1:       return {24'd0, r2[7:0]} * 32'h0101_0101;
            2:       return {16'd0, r2[15:0]} * 32'h0001_0001;
            default: return r2;
        endcase
    endfunction

    task automatic run_op(input vec_t v);
        int          n_busy;
        logic [31:0] ea;
        n_busy = (v.ack_at >= 1 && v.ack_at <= T) ? v.ack_at : T;
        ea     = {v.addr[31:2], 2'b00};
        @(negedge clk);
        mem_aluop = v.op; mem_mem_addr = v.addr; mem_reg2 = v.reg2;
        mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = v.alu; pipe_hold = 1'b0;
        #1;
        chk1("issue_stall", stallreq, 1'b1);
        chk1("issue_req", dbus.req, 1'b0);
        for (int c = 1; c <= n_busy; c++) begin
            @(negedge clk);
            dbus.ack   = (c == v.ack_at);
            dbus.rdata = (c == v.ack_at) ? v.rdata : $urandom;
            #1;
            chk1("busy_req", dbus.req, 1'b1);
            chk1("busy_stall", stallreq, 1'b1);
            chk1("busy_err", bus_err, 1'b0);
            chk("busy_addr", dbus.addr, ea);
            chk("busy_sel", {28'd0, dbus.sel}, {28'd0, v.sel});
            chk1("busy_we", dbus.we, v.we);
            if (v.we) chk("busy_wdata", dbus.wdata, v.wdata);
        end
        @(negedge clk);
        dbus.ack  = 1'b0;
        pipe_hold = (v.hold > 0);
        #1;
        chk1("done_req", dbus.req, 1'b0);
        chk1("done_stall", stallreq, 1'b0);
        chk1("done_err", bus_err, v.err);
        chk("done_wdata", wb_wdata, v.result);
        chk1("done_wreg", wb_wreg, v.wreg);
        chk("done_wd", {27'd0, wb_wd}, 32'd9);
        for (int h = 1; h <= v.hold; h++) begin
            @(negedge clk);
            pipe_hold  = (h < v.hold);
            dbus.ack   = 1'b1;
            dbus.rdata = $urandom;
            #1;
            chk1("hold_req", dbus.req, 1'b0);
            chk1("hold_stall", stallreq, 1'b0);
            chk1("hold_err", bus_err, 1'b0);
            chk("hold_wdata", wb_wdata, v.result);
        end
        @(negedge clk);
        dbus.ack = 1'b0; mem_aluop = OP_NOP; mem_wdata = 32'd0; mem_wreg = 1'b0; pipe_hold = 1'b0;
        #1;
        chk1("after_req", dbus.req, 1'b0);
        chk1("after_stall", stallreq, 1'b0);
        chk1("after_err", bus_err, 1'b0);
    endtask

    task automatic run_pass(input logic [7:0] op, input logic [31:0] alu);
        @(negedge clk);
        mem_aluop = op; mem_wdata = alu; mem_wd = 5'd3; mem_wreg = 1'b1;
        mem_mem_addr = $urandom; dbus.ack = 1'b1;
        #1;
        chk("pass_wdata", wb_wdata, alu);
        chk1("pass_wreg", wb_wreg, 1'b1);
        chk("pass_wd", {27'd0, wb_wd}, 32'd3);
        chk1("pass_stall", stallreq, 1'b0);
        chk1("pass_req", dbus.req, 1'b0);
        @(negedge clk);
        dbus.ack = 1'b0;
        #1;
        chk1("pass_req_after", dbus.req, 1'b0);
        chk1("pass_err_after", bus_err, 1'b0);
    endtask

    logic [7:0] rops [10] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                              EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, OP_ADDU, OP_OR};

    initial begin
        rst = 1'b0;
        mem_aluop = OP_NOP; mem_mem_addr = '0; mem_reg2 = '0; mem_wd = '0;
        mem_wreg = 1'b0; mem_wdata = '0; pipe_hold = 1'b0;
        dbus.ack = 1'b0; dbus.rdata = '0;

        cur = "reset";
        @(negedge clk);
        #1;
        chk1("req", dbus.req, 1'b0);
        chk1("we", dbus.we, 1'b0);
        chk("addr", dbus.addr, 32'd0);
        chk("sel", {28'd0, dbus.sel}, 32'd0);
        chk("wdata", dbus.wdata, 32'd0);
        chk1("bus_err", bus_err, 1'b0);
        chk1("stallreq", stallreq, 1'b0);
        chk("wb_wd", {27'd0, wb_wd}, 32'd0);
        chk1("wb_wreg", wb_wreg, 1'b0);
        chk("wb_wdata", wb_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        cur = "addu";
        run_pass(OP_ADDU, 32'h0000_1234);

        //          op          addr          reg2          rdata         alu           ack hold sel      we    wdata         result        wreg  err
        tbl[0]  = '{EXE_LB_OP,  32'h0000_0101, 32'h0,        32'h11A2_3344, 32'h0,        1, 0, 4'b0100, 1'b0, 32'h0,        32'hFFFF_FFA2, 1'b1, 1'b0};
        tbl[1]  = '{EXE_LBU_OP, 32'h0000_0103, 32'h0,        32'h11A2_33F4, 32'h0,        2, 0, 4'b0001, 1'b0, 32'h0,        32'h0000_00F4, 1'b1, 1'b0};
        tbl[2]  = '{EXE_LH_OP,  32'h0000_0100, 32'h0,        32'h8001_7FFF, 32'h0,        1, 1, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0};
        tbl[3]  = '{EXE_LHU_OP, 32'h0000_0002, 32'h0,        32'h0000_FFEE, 32'h0,        1, 0, 4'b0011, 1'b0, 32'h0,        32'h0000_FFEE, 1'b1, 1'b0};
        tbl[4]  = '{EXE_SH_OP,  32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        32'h0000_0202, 3, 0, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0000_0202, 1'b0, 1'b0};
        tbl[5]  = '{EXE_SB_OP,  32'h0000_0300, 32'h1234_5678, 32'h0,        32'h0000_0300, 1, 0, 4'b1000, 1'b1, 32'h7878_7878, 32'h0000_0300, 1'b0, 1'b0};
        tbl[6]  = '{EXE_LW_OP,  32'h0000_0404, 32'h0,        32'hCAFE_BABE, 32'h0,        1, 2, 4'b1111, 1'b0, 32'h0,        32'hCAFE_BABE, 1'b1, 1'b0};
        tbl[7]  = '{EXE_LW_OP,  32'h0000_0500, 32'h0,        32'h1234_5678, 32'h0,        0, 0, 4'b1111, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1};
        tbl[8]  = '{EXE_LB_OP,  32'h0000_0006, 32'h0,        32'h0000_8000, 32'h0,        4, 0, 4'b0010, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0};
        tbl[9]  = '{EXE_SW_OP,  32'h0000_0010, 32'h0102_0304, 32'h0,        32'h0000_0010, 2, 1, 4'b1111, 1'b1, 32'h0102_0304, 32'h0000_0010, 1'b0, 1'b0};
        tbl[10] = '{EXE_SW_OP,  32'h0000_0020, 32'hAABB_CCDD, 32'h0,        32'h0000_0077, 6, 0, 4'b1111, 1'b1, 32'hAABB_CCDD, 32'h0000_0077, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            $sformat(cur, "vec%0d", i);
            run_op(tbl[i]);
        end

        // Reset while a request is outstanding must drop req without waiting for a clock.
        cur = "rst_busy";
        @(negedge clk);
        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h40; mem_wreg = 1'b1;
        @(negedge clk);
        #1;
        chk1("req_before", dbus.req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("req_async", dbus.req, 1'b0);
        @(negedge clk);
        mem_aluop = OP_NOP; mem_wreg = 1'b0;
        #1;
        chk1("req_held", dbus.req, 1'b0);
        chk1("stall_held", stallreq, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cur = "lhu_after_rst";
        run_op(tbl[3]);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.op = rops[$urandom_range(0, 9)];
            cur  = "rand";
            if (m_size(v.op) == 0) begin
                run_pass(v.op, $urandom);
            end else begin
                v.addr   = $urandom;
`ifdef LSU_ALIGN_CHECK_EN
                v.addr   = v.addr & ~32'(m_size(v.op) - 1);
`endif
                v.reg2   = $urandom;
                v.rdata  = $urandom;
                v.alu    = $urandom;
                v.ack_at = int'($urandom_range(0, T + 2));
                v.hold   = int'($urandom_range(0, 2));
                v.err    = !(v.ack_at >= 1 && v.ack_at <= T);
                v.we     = m_store(v.op);
                v.sel    = m_sel(v.op, v.addr[1:0]);
                v.wdata  = m_wdata(v.op, v.reg2);
                v.wreg   = !v.we;
                v.result = v.we ? v.alu : (v.err ? 32'd0 : m_load(v.op, v.addr[1:0], v.rdata));
                run_op(v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the MEM stage; consumes the EX/MEM pipeline register outputs (aluop, effective address, store operand, wd/wreg/wdata).
- For load/store aluops it runs a req/ack transaction on the data bus, formats load data, and stalls the pipeline until the access completes.
- Non-memory ops pass through combinationally to the MEM/WB register.

Parameters:
- ACK_TIMEOUT, 16: max cycles in BUSY without dbus_ack before abort; 0 disables the timeout counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- mem_aluop  in  `AluOpBus  operation from EX/MEM
- mem_mem_addr  in  `RegBus  effective address
- mem_reg2  in  `RegBus  store operand
- mem_wd  in  `RegAddrBus  destination register
- mem_wreg  in  1  register write enable
- mem_wdata  in  `RegBus  ALU result (non-load ops)
- pipe_hold  in  1  stall[4] from ctrl; MEM stage must not advance
- wb_wd  out  `RegAddrBus  to MEM/WB
- wb_wreg  out  1  to MEM/WB
- wb_wdata  out  `RegBus  to MEM/WB
- stallreq  out  1  stall request to ctrl
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = store
- dbus_addr  out  `RegBus  word address {addr[31:2],2'b00}
- dbus_sel  out  4  byte enables, big-endian lanes
- dbus_wdata  out  `RegBus  store data
- dbus_rdata  in  `RegBus  load data, valid with ack
- dbus_ack  in  1  one-cycle completion
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, async): state=IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, rdata_q=0, bus_err=0, timeout count=0. The outputs stallreq, wb_wd, wb_wreg and wb_wdata are combinational; with NOP inputs they evaluate to 0.
- Memory op set: LB, LBU, LH, LHU, LW, SB, SH, SW. All other aluops: wb_* = mem_* combinationally, stallreq=0, no bus activity.
- States:
  - IDLE: on a mem op, load dbus_* registers and go to BUSY.
  - BUSY: dbus_req=1; dbus_addr, dbus_sel, dbus_we and dbus_wdata held stable. On dbus_ack: capture the formatted load into rdata_q, drop dbus_req, go to DONE.
  - DONE: if pipe_hold=0, go to IDLE (EX/MEM advances on the same edge); otherwise stay in DONE.
- stallreq = (IDLE && mem op) || BUSY. It is 0 in DONE so the pipeline advances.
- Minimum load latency: issue in cycle 0, ack in cycle 1, result in cycle 2.
- wb_wdata in DONE: rdata_q for loads; mem_wdata for stores, which also force wb_wreg=0. wb_wd follows mem_wd.
- Byte lanes (addr[1:0]): 00 = bits [31:24] (sel 1000), 01 = [23:16], 10 = [15:8], 11 = [7:0]. Halfword: addr[1]=0 gives [31:16] (sel 1100), 1 gives [15:0] (0011). Word: sel 1111.
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend.
- Store data replication: SB = {4{reg2[7:0]}}; SH = {2{reg2[15:0]}}; SW = reg2.
- dbus_ack outside BUSY is ignored.
- Timeout (ACK_TIMEOUT>0): count cycles in BUSY. When the count reaches ACK_TIMEOUT without ack: drop req, rdata_q=0, bus_err=1 for one cycle, go to DONE.
- An ack arriving in the same cycle as the timeout wins; no bus_err is raised.
- Reset mid-transaction drops dbus_req immediately. The slave must tolerate an abandoned request.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Enabled: extra output misalign (1 bit). Misaligned cases are LH, LHU or SH with addr[0]=1, and LW or SW with addr[1:0]!=0. For these:
  - no bus request is issued; the FSM goes from IDLE directly to DONE;
  - misalign=1 while in DONE;
  - wb_wreg=0 and stallreq=0 in DONE.
- Disabled: misalign port absent; misaligned accesses ignore the low address bits as the lane rules dictate.

Decomposition:
- Load/store aluop codes already live in defines.v.
- Add `LsuIdle, `LsuBusy and `LsuDone state encodings (2 bits) there.
- One natural sub-module: lsu_fmt (combinational). It produces dbus_sel and replicated wdata from aluop/addr/reg2, and extends load data from aluop/addr/rdata.

Test Plan:
- ADDU, mem_wdata=0x1234 -> wb_wdata=0x1234 same cycle; stallreq=0; dbus_req never asserted.
- LB addr=0x101, ack in 1st BUSY cycle with rdata=0x11A23344 -> sel=0100; wb_wdata=0xFFFFFFA2 in cycle 2; stallreq 1,1,0.
- SH addr=0x202, reg2=0xDEADBEEF, ack after 3 cycles -> dbus_wdata=0xBEEFBEEF, sel=0011, we=1; signals stable until ack; wb_wreg=0.
- LW with pipe_hold=1 for 2 cycles after ack -> FSM stays in DONE; no second request; wb_wdata stable; returns to IDLE when hold drops.
- ACK_TIMEOUT=4, no ack -> req drops after 4 BUSY cycles; bus_err pulses once; wb_wdata=0; next op proceeds normally.
- Reset asserted in BUSY -> dbus_req=0 asynchronously; after release, a fresh LHU addr=0x2 with rdata=0x0000FFEE -> wb_wdata=0x0000FFEE.
